// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Used by pipeline_hazard_ctrl and its sat_counter instances.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 4;

    // ARM "mov r0, r0" is the encoding the datapath loads into ID/EX for a bubble
    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } mem_state_t;

    function automatic logic reg_match(
        input logic                 rd_en,
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] dest
    );
        return rd_en & (src == dest);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: stops at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // count register, held once every bit is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage ARM pipeline with memory-wait FSM and watchdog.
// Build option FORWARDING_EN: only EX-stage load-use matches count as RAW hazards.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 use_src1,
    input  logic                 two_src,
    input  logic                 exe_wb_en,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_mem_r_en,
    input  logic                 mem_wb_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    input  logic                 branch_taken,
    output logic                 freeze_pc,
    output logic                 freeze_if_id,
    output logic                 flush_if_id,
    output logic                 bubble_id_ex,
    output logic                 freeze_back,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     hazard_cnt,
    output logic [CNT_W-1:0]     memwait_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    mem_state_t        state_r;
    mem_state_t        state_nxt_s;
    logic              raw_s;
    logic              exe_match_s;
    logic              mstall_s;
    logic              hazard_inc_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_timeout_r;

    assign exe_match_s = reg_match(use_src1, src1, exe_dest) | reg_match(two_src, src2, exe_dest);

`ifdef FORWARDING_EN
    // MEM-stage results reach the ALU through the forwarding unit, so those ports are not consulted
    logic unused_fwd_s;
    assign unused_fwd_s = ^{mem_wb_en, mem_dest};
    assign raw_s        = exe_mem_r_en & exe_wb_en & exe_match_s;
`else
    logic unused_fwd_s;
    assign unused_fwd_s = exe_mem_r_en;
    assign raw_s        = (exe_wb_en & exe_match_s)
                        | (mem_wb_en & (reg_match(use_src1, src1, mem_dest)
                                      | reg_match(two_src, src2, mem_dest)));
`endif

    assign mstall_s = ((state_r == ST_RUN) & mem_req & ~mem_ready)
                    | ((state_r == ST_MEM_WAIT) & ~mem_ready);

    // memory-wait state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // memory-wait next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nxt_s = ST_MEM_WAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_MEM_WAIT;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // control outputs; a pending branch waits behind the memory stall, and a branch kills any RAW stall
    always_comb begin
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        freeze_back  = 1'b0;
        if (mstall_s) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            freeze_back  = 1'b1;
        end else if (branch_taken) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (raw_s) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            bubble_id_ex = 1'b1;
        end else begin
            freeze_pc    = 1'b0;
        end
    end

    assign hazard_inc_s = raw_s & ~mstall_s & ~branch_taken;

    // watchdog: counts consecutive stalled memory cycles, flag is sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
        end else if (mstall_s) begin
            if (wait_cnt_r != TIMEOUT_V) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if ((wait_cnt_r + WAIT_W'(1'b1)) >= TIMEOUT_V) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
        end else begin
            wait_cnt_r    <= '0;
            mem_timeout_r <= mem_timeout_r;
        end
    end

    assign mem_timeout = mem_timeout_r;

    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hazard_inc_s),
        .cnt (hazard_cnt)
    );

    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk (clk),
        .rst (rst),
        .inc (mstall_s),
        .cnt (memwait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_if_id),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with CNT_W=3 and MEM_TIMEOUT=4.
module tb_pipeline_hazard_ctrl;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic       use_src1, two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic       mem_req, mem_ready, branch_taken;
    logic       freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_back, mem_timeout;
    logic [2:0] hazard_cnt, memwait_cnt, flush_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_haz;

    pipeline_hazard_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .src1         (src1),
        .src2         (src2),
        .use_src1     (use_src1),
        .two_src      (two_src),
        .exe_wb_en    (exe_wb_en),
        .exe_dest     (exe_dest),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .freeze_pc    (freeze_pc),
        .freeze_if_id (freeze_if_id),
        .flush_if_id  (flush_if_id),
        .bubble_id_ex (bubble_id_ex),
        .freeze_back  (freeze_back),
        .mem_timeout  (mem_timeout),
        .hazard_cnt   (hazard_cnt),
        .memwait_cnt  (memwait_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // control vector order: {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_back}
    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        check(tag, 32'({freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_back}), 32'(exp));
    endtask

    task automatic chk_cnt(input string tag, input int h, input int m, input int f);
        check({tag, ".haz"}, 32'(hazard_cnt), 32'(h));
        check({tag, ".mw"},  32'(memwait_cnt), 32'(m));
        check({tag, ".fl"},  32'(flush_cnt), 32'(f));
    endtask

    task automatic idle();
        src1 = 4'd0; src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
        use_src1 = 1'b0; two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_wb_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
    endtask

    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_RAW   = 5'b11010;
    localparam logic [4:0] C_MEM   = 5'b11001;
    localparam logic [4:0] C_FLUSH = 5'b00110;

    initial begin
        idle();
        rst = 1'b1;
        #2;
        chk_ctrl("reset.ctrl", C_IDLE);
        chk_cnt("reset", 0, 0, 0);
        check("reset.tmo", 32'(mem_timeout), 32'd0);
        rst = 1'b0;
        tick();

        // RAW hazard, EX stage, not a load
        exp_haz = 0;
        exe_wb_en = 1'b1; exe_dest = 4'd3; src1 = 4'd3; use_src1 = 1'b1;
        #1;
        chk_ctrl("raw_ex.ctrl", FWD ? C_IDLE : C_RAW);
        tick();
        exp_haz += FWD ? 0 : 1;
        check("raw_ex.haz", 32'(hazard_cnt), 32'(exp_haz));

        // load-use stalls in both builds
        exe_mem_r_en = 1'b1;
        #1;
        chk_ctrl("load_use.ctrl", C_RAW);
        tick();
        exp_haz += 1;
        check("load_use.haz", 32'(hazard_cnt), 32'(exp_haz));

        // RAW via MEM stage on src2
        idle();
        mem_wb_en = 1'b1; mem_dest = 4'd5; two_src = 1'b1; src2 = 4'd5;
        #1;
        chk_ctrl("raw_mem.ctrl", FWD ? C_IDLE : C_RAW);
        tick();
        exp_haz += FWD ? 0 : 1;
        check("raw_mem.haz", 32'(hazard_cnt), 32'(exp_haz));

        // register numbers differ: no stall
        idle();
        exe_wb_en = 1'b1; exe_dest = 4'd4; src1 = 4'd3; use_src1 = 1'b1; exe_mem_r_en = 1'b1;
        #1;
        chk_ctrl("nomatch.ctrl", C_IDLE);
        tick();
        check("nomatch.haz", 32'(hazard_cnt), 32'(exp_haz));

        // single-cycle memory access does not stall
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        chk_ctrl("mem1.ctrl", C_IDLE);
        tick();
        check("mem1.mw", 32'(memwait_cnt), 32'd0);

        // four-cycle memory wait
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_ctrl($sformatf("memw%0d.ctrl", i), C_MEM);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk_ctrl("memw_rel.ctrl", C_IDLE);
        tick();
        check("memw.mw", 32'(memwait_cnt), 32'd4);
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk_ctrl("memw_run.ctrl", C_IDLE);
        tick();

        // branch held during a three-cycle memory stall
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ctrl($sformatf("brw%0d.ctrl", i), C_MEM);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk_ctrl("brw_rel.ctrl", C_FLUSH);
        tick();
        chk_cnt("brw", 0, 3, 1);
        check("brw.tmo", 32'(mem_timeout), 32'd0);

        // branch over a load-use hazard
        idle();
        branch_taken = 1'b1;
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd7; src1 = 4'd7; use_src1 = 1'b1;
        #1;
        chk_ctrl("br_raw.ctrl", C_FLUSH);
        tick();
        chk_cnt("br_raw", 0, 3, 2);

        // watchdog at MEM_TIMEOUT=4
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("wd%0d.tmo", k), 32'(mem_timeout), (k >= 4) ? 32'd1 : 32'd0);
        end
        check("wd.mw", 32'(memwait_cnt), 32'd6);
        mem_ready = 1'b1;
        tick();
        idle();
        tick();
        check("wd_after.tmo", 32'(mem_timeout), 32'd1);
        rst = 1'b1;
        #1;
        check("wd_rst.tmo", 32'(mem_timeout), 32'd0);
        rst = 1'b0;
        tick();

        // hazard counter saturates at 7
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd2; src2 = 4'd2; two_src = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("sat%0d.haz", k), 32'(hazard_cnt), (k > 7) ? 32'd7 : 32'(k));
        end

        // asynchronous reset in the middle of a memory wait
        idle();
        mem_req = 1'b1;
        tick();
        tick();
        check("ar_pre.mw", 32'(memwait_cnt), 32'd2);
        mem_req = 1'b0;
        #1;
        chk_ctrl("ar_pre.ctrl", C_MEM);
        rst = 1'b1;
        #1;
        chk_ctrl("ar.ctrl", C_IDLE);
        chk_cnt("ar", 0, 0, 0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
